branch_target_buffer: RTL

Parametrised branch target buffer and direction predictor for the pipelined MIPS core. Holds up to DEPTH taken branches, each with its branch PC, target address and a CTR_W-bit saturating confidence counter. Fetch sends a lookup and receives a registered taken/target prediction one cycle later. The execute stage's branch resolution updates the table, allocating entries only for taken branches, with lowest-free-slot then round-robin replacement.

---
 rtl/btb_pkg.sv | 33 +++
 rtl/branch_target_buffer_if.sv | 30 +++
 rtl/btb_sat_counter.sv | 32 +++
 rtl/branch_target_buffer.sv | 118 +++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types, constants and saturating-counter helpers for the branch target buffer.
package btb_pkg;
    localparam int BTB_ADDR_W = 13;
    localparam int BTB_DEPTH  = 32;
    localparam int BTB_CTR_W  = 2;

    // Weakly-taken start value and saturation ceiling for a counter of width w.
    function automatic logic [31:0] ctr_weak_t(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] ctr_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam logic [BTB_CTR_W-1:0] CTR_WEAK_T = BTB_CTR_W'(ctr_weak_t(BTB_CTR_W));
    localparam logic [BTB_CTR_W-1:0] CTR_MAX    = BTB_CTR_W'(ctr_max(BTB_CTR_W));

    typedef struct packed {
        logic                  valid;
        logic [BTB_ADDR_W-1:0] tag;
        logic [BTB_ADDR_W-1:0] target;
        logic [BTB_CTR_W-1:0]  ctr;
    } btb_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction
endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch lookup, execute resolution and prediction bundle of the branch target buffer.
interface branch_target_buffer_if
    import btb_pkg::*;
#(
    parameter int ADDR_W = BTB_ADDR_W,
    parameter int DEPTH  = BTB_DEPTH
);
    logic                    lookup_valid;
    logic [ADDR_W-1:0]       lookup_pc;
    logic                    pred_valid;
    logic                    pred_hit;
    logic                    pred_taken;
    logic [ADDR_W-1:0]       pred_target;
    logic                    upd_valid;
    logic [ADDR_W-1:0]       upd_pc;
    logic [ADDR_W-1:0]       upd_target;
    logic                    upd_taken;
    logic                    flush;
    logic [$clog2(DEPTH):0]  occupancy;

    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
        input  pred_valid, pred_hit, pred_taken, pred_target, occupancy
    );

    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
        output pred_valid, pred_hit, pred_taken, pred_target, occupancy
    );
endinterface

// File: rtl/btb_sat_counter.sv
// Per-entry saturating confidence counter; load has priority over inc/dec.
module btb_sat_counter
    import btb_pkg::*;
#(
    parameter int CTR_W = BTB_CTR_W
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    output logic [CTR_W-1:0] value
);
    localparam logic [31:0] MAX_L = ctr_max(CTR_W);

    logic [CTR_W-1:0] value_r;

    // Counter contents only matter once the owning entry is valid, so no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            value_r <= load_val;
        end else if (inc) begin
            value_r <= CTR_W'(sat_inc(32'(value_r), MAX_L));
        end else if (dec) begin
            value_r <= CTR_W'(sat_dec(32'(value_r)));
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;
endmodule

// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer with per-entry direction counters.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ADDR_W = BTB_ADDR_W,
    parameter int DEPTH  = BTB_DEPTH,
    parameter int CTR_W  = BTB_CTR_W
) (
    input logic                     clk,
    input logic                     rst_n,
    branch_target_buffer_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_weak_t(CTR_W));

    typedef logic [IDX_W-1:0] idx_t;

    // Matches are at most one-hot, so OR-ing the set indices yields the match index.
    function automatic idx_t onehot_to_idx(input logic [DEPTH-1:0] oh);
        idx_t idx;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) idx = oh[i] ? (idx | idx_t'(i)) : idx;
        return idx;
    endfunction

    function automatic idx_t lowest_free(input logic [DEPTH-1:0] valid);
        idx_t idx;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) idx = valid[i] ? idx : idx_t'(i);
        return idx;
    endfunction

    logic [DEPTH-1:0]             valid_r;
    logic [DEPTH-1:0][ADDR_W-1:0] tag_r;
    logic [DEPTH-1:0][ADDR_W-1:0] target_r;
    logic [DEPTH-1:0][CTR_W-1:0]  ctr_s;
    idx_t                         rr_ptr_r;
    logic [IDX_W:0]               occ_r;

    logic [DEPTH-1:0] lk_match_s, up_match_s;
    idx_t             lk_idx_s, up_idx_s, free_idx_s, alloc_idx_s;
    logic             lk_hit_s, up_hit_s, free_found_s, upd_en_s, alloc_s;

    logic              pred_valid_r, pred_hit_r, pred_taken_r;
    logic [ADDR_W-1:0] pred_target_r;

    // Tag comparison for both the fetch lookup and the resolving branch.
    always_comb begin
        lk_match_s = '0;
        up_match_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_match_s[i] = valid_r[i] && (tag_r[i] == bus.lookup_pc);
            up_match_s[i] = valid_r[i] && (tag_r[i] == bus.upd_pc);
        end
    end

    assign lk_idx_s     = onehot_to_idx(lk_match_s);
    assign up_idx_s     = onehot_to_idx(up_match_s);
    assign lk_hit_s     = |lk_match_s;
    assign up_hit_s     = |up_match_s;
    assign free_found_s = ~&valid_r;
    assign free_idx_s   = lowest_free(valid_r);
    assign upd_en_s     = bus.upd_valid && !bus.flush;
    assign alloc_s      = upd_en_s && bus.upd_taken && !up_hit_s;
    assign alloc_idx_s  = free_found_s ? free_idx_s : rr_ptr_r;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ctr
        btb_sat_counter #(.CTR_W(CTR_W)) u_ctr (
            .clk      (clk),
            .inc      (upd_en_s && bus.upd_taken && up_match_s[g]),
            .dec      (upd_en_s && !bus.upd_taken && up_match_s[g]),
            .load     (alloc_s && (alloc_idx_s == idx_t'(g))),
            .load_val (CTR_INIT),
            .value    (ctr_s[g])
        );
    end

    // Table valid/tag/target, replacement pointer and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            valid_r  <= '0;
            rr_ptr_r <= '0;
            occ_r    <= '0;
        end else if (alloc_s) begin
            valid_r[alloc_idx_s]  <= 1'b1;
            tag_r[alloc_idx_s]    <= bus.upd_pc;
            target_r[alloc_idx_s] <= bus.upd_target;
            if (free_found_s) begin
                occ_r <= occ_r + (IDX_W + 1)'(1'b1);
            end else begin
                rr_ptr_r <= rr_ptr_r + idx_t'(1'b1);
            end
        end else if (upd_en_s && bus.upd_taken && up_hit_s) begin
            target_r[up_idx_s] <= bus.upd_target;
        end
    end

    // Prediction registers sample pre-update table state.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.lookup_valid) begin
            pred_valid_r  <= 1'b0;
            pred_hit_r    <= 1'b0;
            pred_taken_r  <= 1'b0;
            pred_target_r <= '0;
        end else begin
            pred_valid_r  <= 1'b1;
            pred_hit_r    <= lk_hit_s;
            pred_taken_r  <= lk_hit_s && ctr_s[lk_idx_s][CTR_W-1];
            pred_target_r <= lk_hit_s ? target_r[lk_idx_s] : '0;
        end
    end

    assign bus.pred_valid  = pred_valid_r;
    assign bus.pred_hit    = pred_hit_r;
    assign bus.pred_taken  = pred_taken_r;
    assign bus.pred_target = pred_target_r;
    assign bus.occupancy   = occ_r;
endmodule
